// File: rtl/x1_ioctl_loader_if.sv
// rtl/x1_ioctl_loader_if.sv - ioctl download and memory write port bundle for x1_ioctl_loader
// Purpose: groups the host ioctl stream, the memory write handshake and the status outputs.
// Ports (signals): I_DL, I_IDX, I_WR, I_ADDR, I_DOUT, I_MEM_ACK are driven by the host/memory side;
//   O_WAIT, O_MEM_A, O_MEM_D, O_MEM_REQ, O_CPU_RESET, O_DONE, O_DROP_CNT are driven by the loader.
// Modports: master = host/memory side, slave = loader.
interface x1_ioctl_loader_if #(
    parameter int AW = 18
);
    logic          I_DL;
    logic [7:0]    I_IDX;
    logic          I_WR;
    logic [24:0]   I_ADDR;
    logic [7:0]    I_DOUT;
    logic          O_WAIT;
    logic [AW-1:0] O_MEM_A;
    logic [7:0]    O_MEM_D;
    logic          O_MEM_REQ;
    logic          I_MEM_ACK;
    logic          O_CPU_RESET;
    logic          O_DONE;
    logic [7:0]    O_DROP_CNT;

    modport master (
        output I_DL, I_IDX, I_WR, I_ADDR, I_DOUT, I_MEM_ACK,
        input  O_WAIT, O_MEM_A, O_MEM_D, O_MEM_REQ, O_CPU_RESET, O_DONE, O_DROP_CNT
    );

    modport slave (
        input  I_DL, I_IDX, I_WR, I_ADDR, I_DOUT, I_MEM_ACK,
        output O_WAIT, O_MEM_A, O_MEM_D, O_MEM_REQ, O_CPU_RESET, O_DONE, O_DROP_CNT
    );
endinterface

// File: rtl/x1_ioctl_loader.sv
// rtl/x1_ioctl_loader.sv - ioctl download to SRAM write port loader with CPU reset hold
// Purpose: buffers ioctl bytes in a small FIFO, relocates them into the IPL or CGROM
//   region by ioctl index, writes them to memory, and holds the core in reset while loading.
// Ports: I_CLK (clock), I_RESET (sync active-high reset), bus (x1_ioctl_loader_if.slave).
module x1_ioctl_loader #(
    parameter int            AW          = 18,
    parameter int            FIFO_DEPTH  = 4,
    parameter logic [7:0]    IPL_IDX     = 8'h00,
    parameter logic [AW-1:0] IPL_BASE    = AW'(32'h00000),
    parameter int            IPL_SIZE    = 32768,
    parameter logic [7:0]    CG_IDX      = 8'h01,
    parameter logic [AW-1:0] CG_BASE     = AW'(32'h08000),
    parameter int            CG_SIZE     = 2048,
    parameter int            HOLD_CYCLES = 16
) (
    input  logic               I_CLK,
    input  logic               I_RESET,
    x1_ioctl_loader_if.slave   bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_LVL = (PW+1)'(FIFO_DEPTH);
    localparam logic [PW:0] WAIT_LVL = (PW+1)'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    state_t        state, state_nx;
    logic [7:0]    hold_cnt, hold_cnt_nx;
    logic          done;

    logic [AW-1:0] fifo_a [FIFO_DEPTH];
    logic [7:0]    fifo_d [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count, count_nx;
    logic          wait_q;
    logic [7:0]    drop_cnt;

    logic          is_ipl, is_cg, routed, in_range;
    logic          empty, full, push, drop, req, pop;
    logic [24:0]   region_size;
    logic [AW-1:0] region_base, wr_addr;

    // IPL wins if both indices are configured identically.
    assign is_ipl = (bus.I_IDX == IPL_IDX);
    assign is_cg  = !is_ipl && (bus.I_IDX == CG_IDX);

    always_comb begin
        region_size = '0;
        region_base = '0;
        if (is_ipl) begin
            region_size = 25'(IPL_SIZE);
            region_base = IPL_BASE;
        end else if (is_cg) begin
            region_size = 25'(CG_SIZE);
            region_base = CG_BASE;
        end
    end

    // Range check sees the full 25-bit offset so a huge file can never alias back in.
    assign routed   = bus.I_WR && bus.I_DL && (is_ipl || is_cg);
    assign in_range = (bus.I_ADDR < region_size);
    assign wr_addr  = region_base + bus.I_ADDR[AW-1:0];

    assign empty = (count == '0);
    assign full  = (count == FULL_LVL);
    assign push  = routed && in_range && !full;
    assign drop  = routed && (!in_range || full);
    assign req   = !empty && (state == ST_LOAD || state == ST_DRAIN);
    assign pop   = req && bus.I_MEM_ACK;

    assign count_nx = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wait_q   <= 1'b0;
            drop_cnt <= 8'h00;
        end else begin
            if (push) begin
                fifo_a[wr_ptr] <= wr_addr;
                fifo_d[wr_ptr] <= bus.I_DOUT;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count  <= count_nx;
            // Asserted one entry early so a host reacting a cycle late still fits.
            wait_q <= (count_nx >= WAIT_LVL);
            if (drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state    <= ST_IDLE;
            hold_cnt <= 8'h00;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_cnt_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        hold_cnt_nx = hold_cnt;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.I_DL) state_nx = ST_LOAD;
            end
            ST_LOAD: begin
                if (!bus.I_DL) state_nx = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (bus.I_DL) begin
                    state_nx = ST_LOAD;
                end else if (empty) begin
                    state_nx    = ST_HOLD;
                    hold_cnt_nx = 8'(HOLD_CYCLES);
                end
            end
            ST_HOLD: begin
                // A new download abandons the countdown; the core stays in reset.
                if (bus.I_DL) begin
                    state_nx = ST_LOAD;
                end else if (hold_cnt == 8'd1) begin
                    state_nx = ST_IDLE;
                    done     = 1'b1;
                end else begin
                    hold_cnt_nx = hold_cnt - 8'd1;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bus.O_WAIT      = wait_q;
    assign bus.O_MEM_REQ   = req;
    assign bus.O_MEM_A     = empty ? '0 : fifo_a[rd_ptr];
    assign bus.O_MEM_D     = empty ? 8'h00 : fifo_d[rd_ptr];
    assign bus.O_CPU_RESET = (state != ST_IDLE);
    assign bus.O_DONE      = done;
    assign bus.O_DROP_CNT  = drop_cnt;
endmodule

// File: tb/tb_x1_ioctl_loader.sv
// tb/tb_x1_ioctl_loader.sv - self-checking bench for x1_ioctl_loader
module tb_x1_ioctl_loader;
    localparam int AW    = 18;
    localparam int DEPTH = 4;
    localparam int HOLD  = 16;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    x1_ioctl_loader_if #(.AW(AW)) bus ();
    x1_ioctl_loader #(.AW(AW), .FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .I_CLK   (clk),
        .I_RESET (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: a byte queue plus the load phase (0 idle, 1 loading, 2 draining, 3 holding).
    wr_t mq[$];
    int  m_mode = 0;
    int  m_hold = 0;
    bit  m_wait = 0;
    int  m_drop = 0;

    wr_t got[$];
    int  done_cnt = 0;
    int  done_cyc = 0;
    bit  wait_seen = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin : model
        bit  req, pop, push, was_empty;
        int  base, size;
        wr_t e;
        cyc++;
        if (rst) begin
            mq.delete();
            m_mode = 0;
            m_hold = 0;
            m_wait = 0;
            m_drop = 0;
        end else begin
            was_empty = (mq.size() == 0);
            req  = !was_empty && (m_mode == 1 || m_mode == 2);
            pop  = req && bus.I_MEM_ACK;
            push = 0;
            if (bus.I_WR && bus.I_DL && (bus.I_IDX == 8'h00 || bus.I_IDX == 8'h01)) begin
                base = (bus.I_IDX == 8'h00) ? 0 : 'h8000;
                size = (bus.I_IDX == 8'h00) ? 32768 : 2048;
                if (bus.I_ADDR >= size || mq.size() == DEPTH) begin
                    if (m_drop < 255) m_drop++;
                end else begin
                    push = 1;
                    e.a  = AW'((base + int'(bus.I_ADDR[AW-1:0])) % (1 << AW));
                    e.d  = bus.I_DOUT;
                end
            end
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(e);
            m_wait = (mq.size() >= DEPTH - 1);
            case (m_mode)
                0: if (bus.I_DL) m_mode = 1;
                1: if (!bus.I_DL) m_mode = 2;
                2: if (bus.I_DL) m_mode = 1;
                   else if (was_empty) begin m_mode = 3; m_hold = HOLD; end
                default: if (bus.I_DL) m_mode = 1;
                         else if (m_hold == 1) m_mode = 0;
                         else m_hold--;
            endcase
        end
    end

    always @(negedge clk) begin : compare
        bit mreq, mdone;
        mreq  = (mq.size() > 0) && (m_mode == 1 || m_mode == 2);
        mdone = (m_mode == 3) && (m_hold == 1) && !bus.I_DL && !rst;
        chk("mem_req", bus.O_MEM_REQ, mreq);
        if (mreq) begin
            chk("mem_a", bus.O_MEM_A, mq[0].a);
            chk("mem_d", bus.O_MEM_D, mq[0].d);
        end
        chk("wait", bus.O_WAIT, m_wait);
        chk("cpu_reset", bus.O_CPU_RESET, (m_mode != 0));
        chk("done", bus.O_DONE, mdone);
        chk("drop_cnt", bus.O_DROP_CNT, m_drop);
        if (bus.O_MEM_REQ && bus.I_MEM_ACK) got.push_back('{a: bus.O_MEM_A, d: bus.O_MEM_D});
        if (bus.O_DONE) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.O_WAIT) wait_seen = 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.I_DL = 1'b0;
        bus.I_WR = 1'b0;
        bus.I_MEM_ACK = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        got.delete();
        done_cnt = 0;
        wait_seen = 0;
    endtask

    task automatic wr(input logic [7:0] idx, input logic [24:0] addr, input logic [7:0] d);
        bus.I_IDX  = idx;
        bus.I_ADDR = addr;
        bus.I_DOUT = d;
        bus.I_WR   = 1'b1;
        tick();
        bus.I_WR   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            tick();
            n++;
        end
        if (done_cnt == 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=0 required=1");
        end
    endtask

    initial begin
        int w;
        bus.I_DL = 0; bus.I_IDX = 0; bus.I_WR = 0; bus.I_ADDR = 0; bus.I_DOUT = 0; bus.I_MEM_ACK = 0;

        // Reset state
        do_reset();
        chk("rst_req", bus.O_MEM_REQ, 0);
        chk("rst_a", bus.O_MEM_A, 0);
        chk("rst_d", bus.O_MEM_D, 0);
        chk("rst_wait", bus.O_WAIT, 0);
        chk("rst_cpu", bus.O_CPU_RESET, 0);
        chk("rst_done", bus.O_DONE, 0);
        chk("rst_drop", bus.O_DROP_CNT, 0);

        // 1: IPL load of four bytes, ACK tied high
        bus.I_MEM_ACK = 1; bus.I_DL = 1; tick();
        w = 0;
        for (int i = 0; i < 4; i++) begin
            w = cyc;
            wr(8'h00, 25'(i), 8'hA0 + 8'(i));
        end
        bus.I_DL = 0;
        wait_done(40);
        tick(); tick(); tick();
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_lat", done_cyc - w, HOLD + 2);
        chk("t1_wait_seen", wait_seen, 0);
        chk("t1_nwr", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            chk("t1_addr", got[i].a, i);
            chk("t1_data", got[i].d, 8'hA0 + i);
        end
        chk("t1_cpu_released", bus.O_CPU_RESET, 0);

        // 2: CGROM relocation, 1-cycle latency
        do_reset();
        bus.I_DL = 1; tick();
        wr(8'h01, 25'd5, 8'h3C);
        chk("t2_req", bus.O_MEM_REQ, 1);
        chk("t2_addr", bus.O_MEM_A, 18'h08005);
        chk("t2_data", bus.O_MEM_D, 8'h3C);
        bus.I_MEM_ACK = 1; tick(); tick();

        // 3: out-of-range drop, unknown index ignored
        do_reset();
        bus.I_DL = 1; tick();
        wr(8'h01, 25'd2048, 8'h55);
        chk("t3_drop", bus.O_DROP_CNT, 1);
        chk("t3_req", bus.O_MEM_REQ, 0);
        wr(8'h07, 25'd3, 8'h66);
        chk("t3_drop_idx7", bus.O_DROP_CNT, 1);
        chk("t3_req_idx7", bus.O_MEM_REQ, 0);
        wr(8'h00, 25'h1000000, 8'h77);
        chk("t3_drop_high", bus.O_DROP_CNT, 2);

        // 4: back-pressure and overflow at DEPTH=4
        do_reset();
        bus.I_DL = 1; tick();
        for (int i = 0; i < 5; i++) begin
            wr(8'h00, 25'h10 + 25'(i), 8'h50 + 8'(i));
            if (i == 1) chk("t4_wait_lo", bus.O_WAIT, 0);
            if (i == 2) chk("t4_wait_hi", bus.O_WAIT, 1);
        end
        chk("t4_drop", bus.O_DROP_CNT, 1);
        bus.I_MEM_ACK = 1;
        for (int i = 0; i < 6; i++) tick();
        chk("t4_nwr", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            chk("t4_addr", got[i].a, 'h10 + i);
            chk("t4_data", got[i].d, 8'h50 + i);
        end
        chk("t4_wait_clear", bus.O_WAIT, 0);
        bus.I_DL = 0;
        wait_done(40);

        // 5: download restarted during the hold countdown
        do_reset();
        bus.I_MEM_ACK = 1; bus.I_DL = 1; tick();
        wr(8'h00, 25'd0, 8'h11);
        bus.I_DL = 0;
        for (int i = 0; i < 8; i++) tick();
        chk("t5_in_hold_cpu", bus.O_CPU_RESET, 1);
        chk("t5_no_done", done_cnt, 0);
        bus.I_DL = 1;
        wr(8'h00, 25'd1, 8'h22);
        bus.I_DL = 0;
        wait_done(40);
        tick(); tick();
        chk("t5_done_cnt", done_cnt, 1);
        chk("t5_nwr", got.size(), 2);
        if (got.size() == 2) begin
            chk("t5_addr", got[1].a, 1);
            chk("t5_data", got[1].d, 8'h22);
        end

        // 6: reset in the middle of a load
        do_reset();
        bus.I_DL = 1; tick();
        wr(8'h00, 25'd8, 8'h88);
        wr(8'h00, 25'd9, 8'h99);
        rst = 1; bus.I_DL = 0;
        tick();
        chk("t6_req", bus.O_MEM_REQ, 0);
        chk("t6_cpu", bus.O_CPU_RESET, 0);
        rst = 0; bus.I_MEM_ACK = 1;
        got.delete();
        for (int i = 0; i < 6; i++) tick();
        chk("t6_no_stale", got.size(), 0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            if ($urandom_range(0, 99) < 3) bus.I_DL = ~bus.I_DL;
            bus.I_MEM_ACK = ($urandom_range(0, 3) != 0);
            if (bus.I_DL && $urandom_range(0, 1) == 1 && (!bus.O_WAIT || $urandom_range(0, 7) == 0)) begin
                r = $urandom_range(0, 9);
                bus.I_IDX  = (r < 4) ? 8'h00 : (r < 8) ? 8'h01 : 8'(r);
                r = $urandom_range(0, 9);
                bus.I_ADDR = (r < 6) ? 25'($urandom_range(0, 40)) :
                             (r == 6) ? 25'($urandom_range(2040, 2060)) :
                             (r == 7) ? 25'($urandom_range(32760, 32775)) : 25'($urandom);
                bus.I_DOUT = 8'($urandom);
                bus.I_WR   = 1'b1;
            end else begin
                bus.I_WR = 1'b0;
            end
            tick();
        end
        bus.I_WR = 0; bus.I_DL = 0; bus.I_MEM_ACK = 1;
        for (int i = 0; i < 60; i++) tick();
        chk("rand_idle_cpu", bus.O_CPU_RESET, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
